// File: rtl/reg_load_arbiter_pkg.sv
// reg_arb_pkg: shared types, defaults and rotate helper for reg_load_arbiter.
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, LOCKED} state_t;
  localparam int DEF_WIDTH = 16;
  function automatic logic [7:0] rotr(input logic [7:0] v, input int n, input int sh);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[i] = v[3'((i + sh) % n)];
    return r;
  endfunction
endpackage

// File: rtl/reg_load_arbiter_if.sv
// reg_load_arbiter_if: requester and register-side signals of the arbiter.
// Optional lock bus present only when REG_ARB_LOCK_EN is defined.
interface reg_load_arbiter_if import reg_arb_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NREQ-1:0]       req, gnt;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr, clr_done, reg_ei, reg_rst, busy;
  logic [WIDTH-1:0]      reg_d;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  modport slave (
    input  req, wdata, clr,
    output gnt, clr_done, reg_d, reg_ei, reg_rst, busy
`ifdef REG_ARB_LOCK_EN
    , input lock
`endif
  );
  modport master (
    output req, wdata, clr,
    input  gnt, clr_done, reg_d, reg_ei, reg_rst, busy
`ifdef REG_ARB_LOCK_EN
    , output lock
`endif
  );
endinterface

// File: rtl/reg_load_arbiter_rr_pick.sv
// rr_pick: round-robin choice of the first request after last, as one-hot and index.
module rr_pick import reg_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);
  logic [7:0] pad, rv;
  int k;
  always_comb begin
    pad = '0;
    pad[NREQ-1:0] = req;
    rv = rotr(pad, NREQ, (int'(last) + 1) % NREQ);
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) if (rv[i]) k = i;
    idx = IW'((int'(last) + 1 + k) % NREQ);
    pick = |rv ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin FSM driving one shared load-enabled register.
// Define REG_ARB_LOCK_EN to add lock[] and the LOCKED burst state.
module reg_load_arbiter import reg_arb_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  reg_load_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nxt;
  logic [IW-1:0] w, w_nxt, last, last_nxt, pidx;
  logic [NREQ-1:0] pick, gnt_nxt, gnt_q;
  logic [WIDTH-1:0] d_nxt, d_q;
  logic [WIDTH-1:0] wd [NREQ];
  logic ei_q, rr_q, busy_q;
  for (genvar i = 0; i < NREQ; i++) assign wd[i] = bus.wdata[i*WIDTH +: WIDTH];
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(bus.req), .last(last), .pick(pick), .idx(pidx));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      w      <= '0;
      last   <= IW'(NREQ - 1);
      d_q    <= '0;
      gnt_q  <= '0;
      ei_q   <= 1'b0;
      rr_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      w      <= w_nxt;
      last   <= last_nxt;
      d_q    <= d_nxt;
      gnt_q  <= gnt_nxt;
      ei_q   <= state_nxt == WRITE;
      rr_q   <= state_nxt == CLEAR;
      busy_q <= state_nxt != IDLE;
    end
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    last_nxt  = last;
    d_nxt     = d_q;
    unique case (state)
      IDLE:
        if (bus.clr) state_nxt = CLEAR;
        else if (|pick) begin
          state_nxt = WRITE;
          w_nxt     = pidx;
          last_nxt  = pidx;
          d_nxt     = wd[pidx];
        end
`ifdef REG_ARB_LOCK_EN
      WRITE: state_nxt = bus.lock[w] ? LOCKED : IDLE;
      LOCKED:
        if (bus.req[w]) begin
          state_nxt = WRITE;
          d_nxt     = wd[w];
        end else if (!bus.lock[w]) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_comb gnt_nxt = state_nxt == WRITE ? NREQ'(1) << w_nxt : '0;
  assign bus.gnt      = gnt_q;
  assign bus.reg_d    = d_q;
  assign bus.reg_ei   = ei_q;
  assign bus.reg_rst  = rr_q;
  assign bus.clr_done = rr_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: directed checks of arbitration, clear priority, reset abort and lock bursts.
// Lock scenario compiled only with REG_ARB_LOCK_EN.
module tb_reg_load_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] wd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  reg_load_arbiter_if #(.NREQ(4), .WIDTH(16)) bus ();
  reg_load_arbiter #(.NREQ(4), .WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [3:0] g, input logic ei, input logic rr, input logic b);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".reg_ei"}, 32'(bus.reg_ei), 32'(ei));
    chk({tag, ".reg_rst"}, 32'(bus.reg_rst), 32'(rr));
    chk({tag, ".clr_done"}, 32'(bus.clr_done), 32'(rr));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req = '0;
    bus.clr = 1'b0;
    bus.wdata = '0;
`ifdef REG_ARB_LOCK_EN
    bus.lock = '0;
`endif
    #12;
    outs("reset", 4'b0000, 0, 0, 0);
    chk("reset.reg_d", 32'(bus.reg_d), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.wdata[32 +: 16] = 16'hA5A5;
    bus.req = 4'b0100;
    tick;
    outs("t1.write", 4'b0100, 1, 0, 1);
    chk("t1.reg_d", 32'(bus.reg_d), 32'hA5A5);
    bus.req = '0;
    tick;
    outs("t1.idle", 4'b0000, 0, 0, 0);
    chk("t1.hold", 32'(bus.reg_d), 32'hA5A5);
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) bus.wdata[i*16 +: 16] = wd[i];
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick;
      outs($sformatf("t2.grant%0d", k), 4'(1 << k), 1, 0, 1);
      chk($sformatf("t2.reg_d%0d", k), 32'(bus.reg_d), 32'(wd[k]));
      bus.req[k] = 1'b0;
      tick;
      outs($sformatf("t2.idle%0d", k), 4'b0000, 0, 0, 0);
    end
    bus.clr = 1'b1;
    bus.req = 4'b0010;
    tick;
    outs("t3.clear", 4'b0000, 0, 1, 1);
    bus.clr = 1'b0;
    tick;
    outs("t3.idle", 4'b0000, 0, 0, 0);
    tick;
    outs("t3.write", 4'b0010, 1, 0, 1);
    chk("t3.reg_d", 32'(bus.reg_d), 32'(wd[1]));
    bus.req = '0;
    tick;
    bus.req = 4'b1000;
    tick;
    outs("t4.write", 4'b1000, 1, 0, 1);
    rst = 1'b0;
    #1;
    outs("t4.abort", 4'b0000, 0, 0, 0);
    rst = 1'b1;
    tick;
    outs("t4.retry", 4'b1000, 1, 0, 1);
    bus.req = '0;
    tick;
    bus.req = 4'b0001;
    tick;
    outs("t5.setup", 4'b0001, 1, 0, 1);
    bus.req = '0;
    tick;
    tick;
    outs("t5.gap", 4'b0000, 0, 0, 0);
    bus.req = 4'b1001;
    tick;
    outs("t5.first", 4'b1000, 1, 0, 1);
    bus.req = 4'b0001;
    tick;
    outs("t5.idle", 4'b0000, 0, 0, 0);
    tick;
    outs("t5.second", 4'b0001, 1, 0, 1);
    bus.req = '0;
    tick;
`ifdef REG_ARB_LOCK_EN
    bus.lock = 4'b0010;
    bus.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick;
      outs($sformatf("t6.write%0d", k), 4'b0010, 1, 0, 1);
      bus.req = 4'b0001;
      tick;
      outs($sformatf("t6.locked%0d", k), 4'b0000, 0, 0, 1);
      if (k < 2) bus.req = 4'b0011;
    end
    tick;
    outs("t6.hold", 4'b0000, 0, 0, 1);
    bus.lock = '0;
    tick;
    outs("t6.exit", 4'b0000, 0, 0, 0);
    tick;
    outs("t6.grant0", 4'b0001, 1, 0, 1);
    bus.req = '0;
    tick;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
